// File: rtl/mul32_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// mul32_seq_ctrl_if
// Request/response bundle between a requester and the mul32_seq_ctrl
// sequential multiplier.
//   start : request pulse (requester -> controller)
//   a, b  : 32-bit unsigned operands, sampled with start
//   busy  : controller is not idle
//   done  : one-cycle completion pulse
//   p     : 64-bit product, held until the next completion
// ---------------------------------------------------------------------------
interface mul32_seq_ctrl_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] p;

    modport master (output start, a, b, input  busy, done, p);
    modport slave  (input  start, a, b, output busy, done, p);
endinterface

// File: rtl/mul32_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mul32_seq_ctrl
// Computes an unsigned 32x32 -> 64 product with a single shared 16x16
// combinational multiplier, stepping the four partial products over four
// cycles and shift-accumulating them into a 64-bit register.
// Latency: start accepted at edge k, done high in the cycle after edge k+4,
// back in IDLE after edge k+5.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : slave side of mul32_seq_ctrl_if (start/a/b in, busy/done/p out)
// Also contains multiplier_16_bit, the shared combinational multiplier.
// ---------------------------------------------------------------------------
module multiplier_16_bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);
    assign p = a * b;
endmodule

module mul32_seq_ctrl #(
    parameter int HALF_W = 16   // must stay 16 to match multiplier_16_bit
) (
    input  logic             clk,
    input  logic             rst,
    mul32_seq_ctrl_if.slave  bus
);
    localparam int FULL_W = 2 * HALF_W;
    localparam int PROD_W = 4 * HALF_W;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state, state_nxt;
    logic [1:0]          step;
    logic [FULL_W-1:0]   a_r, b_r;
    logic [PROD_W-1:0]   acc, p_q, pp_sh, acc_sum;
    logic [HALF_W-1:0]   mul_a, mul_b;
    logic [FULL_W-1:0]   pp;
    logic                busy_q, done_q;

    // Operand mux: only latched operands feed the multiplier, so changes on
    // the live a/b inputs cannot disturb an operation in flight.
    always_comb begin
        mul_a = a_r[HALF_W-1:0];
        mul_b = b_r[HALF_W-1:0];
        case (step)
            2'd0: begin mul_a = a_r[HALF_W-1:0];      mul_b = b_r[HALF_W-1:0];      end
            2'd1: begin mul_a = a_r[FULL_W-1:HALF_W]; mul_b = b_r[HALF_W-1:0];      end
            2'd2: begin mul_a = a_r[HALF_W-1:0];      mul_b = b_r[FULL_W-1:HALF_W]; end
            default: begin mul_a = a_r[FULL_W-1:HALF_W]; mul_b = b_r[FULL_W-1:HALF_W]; end
        endcase
    end

    multiplier_16_bit u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (pp)
    );

    // Partial-product alignment: cross terms sit at bit 16, hi*hi at bit 32.
    always_comb begin
        pp_sh = '0;
        case (step)
            2'd0:    pp_sh = {{FULL_W{1'b0}}, pp};
            2'd1,
            2'd2:    pp_sh = {{HALF_W{1'b0}}, pp, {HALF_W{1'b0}}};
            default: pp_sh = {pp, {FULL_W{1'b0}}};
        endcase
    end

    assign acc_sum = acc + pp_sh;

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = CALC;
            CALC:    if (step == 2'd3) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and registered handshake outputs. busy/done are derived from
    // the next state so they line up with the state register without any
    // combinational path from start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step   <= 2'd0;
            a_r    <= '0;
            b_r    <= '0;
            acc    <= '0;
            p_q    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (state_nxt != IDLE);
            done_q <= (state_nxt == DONE);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_r  <= bus.a;
                        b_r  <= bus.b;
                        acc  <= '0;
                        step <= 2'd0;
                    end
                end
                CALC: begin
                    acc  <= acc_sum;
                    step <= step + 2'd1;
                    if (step == 2'd3) p_q <= acc_sum;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.p    = p_q;
endmodule
